ym_reg_file_v2: RTL and testbench



---
 rtl/ym_reg_file_v2.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_ym_reg_file_v2.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ym_reg_file_v2.sv
// ---------------------------------------------------------------------------
// ym_reg_file_v2 -- YM-style bus register file with busy timing and timer flags
//
// A host bus writes an address byte (A0=0) and then a data byte (A0=1).
// An accepted data write updates the register array and announces itself on
// wr_stb/wr_addr/wr_data. It then blocks further data writes for BUSY_CYCLES
// clocks. A data write that arrives while busy is dropped and sets the sticky
// OVR flag. Timer overflow pulses set FLAG_A/FLAG_B when enabled in reg 0x14.
// A read returns the status byte {busy, OVR, 0000, FLAG_B, FLAG_A}.
//
// Ports
//   phiM     in   clock
//   IC       in   asynchronous active-high reset
//   CS_b     in   chip select, active-low, qualifies WR_b / RD_b
//   WR_b     in   write strobe, active-low
//   RD_b     in   read strobe, active-low
//   A0       in   0 = address write, 1 = data write
//   Din      in   [7:0] bus write data
//   TM_1     in   timer A overflow pulse
//   TM_2     in   timer B overflow pulse
//   Dout     out  [7:0] registered read data (0x00 when not driven)
//   Dout_oe  out  high for the one cycle Dout carries a read result
//   IRQ_b    out  interrupt, active-low, = ~(FLAG_A | FLAG_B)
//   CT_1     out  reg 0x1B bit 7
//   CT_2     out  reg 0x1B bit 6
//   wr_stb   out  one-cycle pulse per accepted data write
//   wr_addr  out  [ADDR_W-1:0] address of the last accepted write
//   wr_data  out  [7:0] data of the last accepted write
// ---------------------------------------------------------------------------

// Invariant checker for the register file; carries no synthesizable logic.
module ym_reg_file_v2_chk #(
    parameter int BUSY_CYCLES = 68
) (
    input logic       clk,
    input logic       rst,
    input logic       accept,
    input logic [7:0] busy_cnt,
    input logic [7:0] dout,
    input logic       dout_oe,
    input logic       irq_b,
    input logic       flag_a,
    input logic       flag_b
);

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        busy_cnt <= 8'(BUSY_CYCLES));

    a_accept_idle: assert property (@(posedge clk) disable iff (rst)
        accept |-> (busy_cnt == 8'd0));

    a_dout_quiet: assert property (@(posedge clk) disable iff (rst)
        !dout_oe |-> (dout == 8'h00));

    a_irq_match: assert property (@(posedge clk) disable iff (rst)
        irq_b == ~(flag_a | flag_b));

endmodule

module ym_reg_file_v2 #(
    parameter int ADDR_W      = 8,
    parameter int BUSY_CYCLES = 68
) (
    input  logic              phiM,
    input  logic              IC,
    input  logic              CS_b,
    input  logic              WR_b,
    input  logic              RD_b,
    input  logic              A0,
    input  logic [7:0]        Din,
    input  logic              TM_1,
    input  logic              TM_2,
    output logic [7:0]        Dout,
    output logic              Dout_oe,
    output logic              IRQ_b,
    output logic              CT_1,
    output logic              CT_2,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int              NREGS   = 1 << ADDR_W;
    localparam logic [7:0]      TMR_A8  = 8'h14;
    localparam logic [ADDR_W-1:0] TMR_IDX = ADDR_W'(8'h14);
    localparam logic [ADDR_W-1:0] CT_IDX  = ADDR_W'(8'h1B);

    // State
    logic [7:0]        regs_r [NREGS];
    logic [7:0]        addr_r;
    logic              wr_hist_r;
    logic              rd_hist_r;
    logic [7:0]        busy_cnt_r;
    logic              ovr_r;
    logic              flag_a_r;
    logic              flag_b_r;
    logic [7:0]        dout_r;
    logic              dout_oe_r;
    logic              irq_b_r;
    logic              wr_stb_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [7:0]        wr_data_r;

    // Combinational decode
    logic              wr_act_s;
    logic              rd_act_s;
    logic              wr_edge_s;
    logic              rd_edge_s;
    logic              busy_s;
    logic              in_range_s;
    logic              data_wr_s;
    logic              accept_s;
    logic              drop_s;
    logic              ovr_nxt_s;
    logic              flag_a_nxt_s;
    logic              flag_b_nxt_s;
    logic [7:0]        status_s;
    logic [ADDR_W-1:0] reg_idx_s;

    // Strobe qualification and edge detection; the history register is
    // cleared by reset, so a strobe held across reset release is a new edge.
    always_comb begin
        wr_act_s  = ~CS_b & ~WR_b;
        rd_act_s  = ~CS_b & ~RD_b;
        wr_edge_s = wr_act_s & ~wr_hist_r;
        rd_edge_s = rd_act_s & ~rd_hist_r;
    end

    // Data-write classification: accepted, dropped (busy) or ignored (range).
    always_comb begin
        busy_s     = (busy_cnt_r != 8'd0);
        in_range_s = ({1'b0, addr_r} < 9'(NREGS));
        data_wr_s  = wr_edge_s & A0;
        accept_s   = data_wr_s & in_range_s & ~busy_s;
        drop_s     = data_wr_s & in_range_s & busy_s;
        reg_idx_s  = addr_r[ADDR_W-1:0];
        status_s   = {busy_s, ovr_r, 4'b0000, flag_b_r, flag_a_r};
    end

    // Next OVR: a drop wins over the read-triggered clear.
    always_comb begin
        ovr_nxt_s = ovr_r;
        if (drop_s) begin
            ovr_nxt_s = 1'b1;
        end else if (rd_edge_s) begin
            ovr_nxt_s = 1'b0;
        end else begin
            ovr_nxt_s = ovr_r;
        end
    end

    // Next timer flags: a set on the same cycle as a clear keeps the flag set.
    always_comb begin
        flag_a_nxt_s = flag_a_r;
        if (TM_1 && regs_r[TMR_IDX][2]) begin
            flag_a_nxt_s = 1'b1;
        end else if (accept_s && (addr_r == TMR_A8) && Din[4]) begin
            flag_a_nxt_s = 1'b0;
        end else begin
            flag_a_nxt_s = flag_a_r;
        end
    end

    // Next timer flag B, same rules as flag A with bits 3 / 5.
    always_comb begin
        flag_b_nxt_s = flag_b_r;
        if (TM_2 && regs_r[TMR_IDX][3]) begin
            flag_b_nxt_s = 1'b1;
        end else if (accept_s && (addr_r == TMR_A8) && Din[5]) begin
            flag_b_nxt_s = 1'b0;
        end else begin
            flag_b_nxt_s = flag_b_r;
        end
    end

    // Strobe history for edge detection.
    always_ff @(posedge phiM or posedge IC) begin
        if (IC) begin
            wr_hist_r <= 1'b0;
            rd_hist_r <= 1'b0;
        end else begin
            wr_hist_r <= wr_act_s;
            rd_hist_r <= rd_act_s;
        end
    end

    // Address register: any address write latches the full byte, even busy.
    always_ff @(posedge phiM or posedge IC) begin
        if (IC) begin
            addr_r <= 8'h00;
        end else if (wr_edge_s && !A0) begin
            addr_r <= Din;
        end else begin
            addr_r <= addr_r;
        end
    end

    // Register array update on accepted data writes.
    always_ff @(posedge phiM or posedge IC) begin
        if (IC) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (accept_s) begin
            regs_r[reg_idx_s] <= Din;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Busy counter: loaded on acceptance, so busy is visible from the next
    // cycle for exactly BUSY_CYCLES cycles. Drops never reload it.
    always_ff @(posedge phiM or posedge IC) begin
        if (IC) begin
            busy_cnt_r <= 8'd0;
        end else if (accept_s) begin
            busy_cnt_r <= 8'(BUSY_CYCLES);
        end else if (busy_s) begin
            busy_cnt_r <= busy_cnt_r - 8'd1;
        end else begin
            busy_cnt_r <= busy_cnt_r;
        end
    end

    // Sticky status flags and the interrupt derived from their next values.
    always_ff @(posedge phiM or posedge IC) begin
        if (IC) begin
            ovr_r    <= 1'b0;
            flag_a_r <= 1'b0;
            flag_b_r <= 1'b0;
            irq_b_r  <= 1'b1;
        end else begin
            ovr_r    <= ovr_nxt_s;
            flag_a_r <= flag_a_nxt_s;
            flag_b_r <= flag_b_nxt_s;
            irq_b_r  <= ~(flag_a_nxt_s | flag_b_nxt_s);
        end
    end

    // Read port: the status sampled at the read edge (pre-write) is shown
    // for one cycle; the bus is quiet otherwise.
    always_ff @(posedge phiM or posedge IC) begin
        if (IC) begin
            dout_r    <= 8'h00;
            dout_oe_r <= 1'b0;
        end else if (rd_edge_s) begin
            dout_r    <= status_s;
            dout_oe_r <= 1'b1;
        end else begin
            dout_r    <= 8'h00;
            dout_oe_r <= 1'b0;
        end
    end

    // Write announcement: strobe pulses once, address/data held until the
    // next accepted write.
    always_ff @(posedge phiM or posedge IC) begin
        if (IC) begin
            wr_stb_r  <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 8'h00;
        end else if (accept_s) begin
            wr_stb_r  <= 1'b1;
            wr_addr_r <= reg_idx_s;
            wr_data_r <= Din;
        end else begin
            wr_stb_r  <= 1'b0;
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
        end
    end

    assign Dout    = dout_r;
    assign Dout_oe = dout_oe_r;
    assign IRQ_b   = irq_b_r;
    assign wr_stb  = wr_stb_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;

    // Control-timer bits come straight from the array.
    assign CT_1 = regs_r[CT_IDX][7];
    assign CT_2 = regs_r[CT_IDX][6];

    ym_reg_file_v2_chk #(
        .BUSY_CYCLES (BUSY_CYCLES)
    ) u_chk (
        .clk      (phiM),
        .rst      (IC),
        .accept   (accept_s),
        .busy_cnt (busy_cnt_r),
        .dout     (dout_r),
        .dout_oe  (dout_oe_r),
        .irq_b    (irq_b_r),
        .flag_a   (flag_a_r),
        .flag_b   (flag_b_r)
    );

endmodule

// File: tb/tb_ym_reg_file_v2.sv
// ---------------------------------------------------------------------------
// tb_ym_reg_file_v2 -- self-checking bench for ym_reg_file_v2.
// Two instances (ADDR_W=8 and ADDR_W=5) share the bus and are compared every
// cycle against a transaction-level reference model, plus directed checks
// against fixed expected constants.
// ---------------------------------------------------------------------------
module tb_ym_reg_file_v2;

    localparam int BUSY = 68;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       ic, cs_b, wr_b, rd_b, a0, tm_1, tm_2;
    logic [7:0] din;

    logic [7:0] d0_dout, d1_dout, d0_wd, d1_wd;
    logic       d0_oe, d1_oe, d0_irq, d1_irq, d0_ct1, d1_ct1, d0_ct2, d1_ct2;
    logic       d0_stb, d1_stb;
    logic [7:0] d0_wa;
    logic [4:0] d1_wa;

    ym_reg_file_v2 #(.ADDR_W(8), .BUSY_CYCLES(BUSY)) u_dut8 (
        .phiM(clk), .IC(ic), .CS_b(cs_b), .WR_b(wr_b), .RD_b(rd_b), .A0(a0),
        .Din(din), .TM_1(tm_1), .TM_2(tm_2), .Dout(d0_dout), .Dout_oe(d0_oe),
        .IRQ_b(d0_irq), .CT_1(d0_ct1), .CT_2(d0_ct2), .wr_stb(d0_stb),
        .wr_addr(d0_wa), .wr_data(d0_wd));

    ym_reg_file_v2 #(.ADDR_W(5), .BUSY_CYCLES(BUSY)) u_dut5 (
        .phiM(clk), .IC(ic), .CS_b(cs_b), .WR_b(wr_b), .RD_b(rd_b), .A0(a0),
        .Din(din), .TM_1(tm_1), .TM_2(tm_2), .Dout(d1_dout), .Dout_oe(d1_oe),
        .IRQ_b(d1_irq), .CT_1(d1_ct1), .CT_2(d1_ct2), .wr_stb(d1_stb),
        .wr_addr(d1_wa), .wr_data(d1_wd));

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    int         aw [2] = '{8, 5};
    int         cyc = 0;                 // index of the state currently shown
    logic [7:0] m_regs [2][256];
    logic [7:0] m_addr [2];
    int         m_busy_end [2];          // first state index that is not busy
    logic       m_ovr [2], m_fa [2], m_fb [2], m_pw [2], m_pr [2];
    logic [7:0] e_dout [2], e_wa [2], e_wd [2];
    logic       e_oe [2], e_irq [2], e_stb [2];

    function automatic void m_reset(input int i);
        for (int k = 0; k < 256; k++) m_regs[i][k] = 8'h00;
        m_addr[i] = 8'h00; m_busy_end[i] = 0;
        m_ovr[i] = 1'b0; m_fa[i] = 1'b0; m_fb[i] = 1'b0;
        m_pw[i] = 1'b0; m_pr[i] = 1'b0;
        e_dout[i] = 8'h00; e_oe[i] = 1'b0; e_irq[i] = 1'b1;
        e_stb[i] = 1'b0; e_wa[i] = 8'h00; e_wd[i] = 8'h00;
    endfunction

    function automatic void m_step(input int i);
        logic busy, we, re, acc, drop, set_a, set_b, clr_a, clr_b;
        logic [7:0] st;
        busy = (cyc < m_busy_end[i]);
        st   = {busy, m_ovr[i], 4'b0000, m_fb[i], m_fa[i]};
        we   = !cs_b && !wr_b && !m_pw[i];
        re   = !cs_b && !rd_b && !m_pr[i];
        m_pw[i] = !cs_b && !wr_b;
        m_pr[i] = !cs_b && !rd_b;
        acc = 1'b0; drop = 1'b0;
        if (we) begin
            if (!a0) m_addr[i] = din;
            else if (int'(m_addr[i]) < (1 << aw[i])) begin
                if (busy) drop = 1'b1; else acc = 1'b1;
            end
        end
        set_a = tm_1 && m_regs[i][20][2];
        set_b = tm_2 && m_regs[i][20][3];
        clr_a = acc && (m_addr[i] == 8'h14) && din[4];
        clr_b = acc && (m_addr[i] == 8'h14) && din[5];
        e_dout[i] = re ? st : 8'h00;
        e_oe[i]   = re;
        e_stb[i]  = acc;
        if (acc) begin
            m_regs[i][m_addr[i]] = din;
            m_busy_end[i] = cyc + 1 + BUSY;
            e_wa[i] = m_addr[i];
            e_wd[i] = din;
        end
        if (drop) m_ovr[i] = 1'b1;
        else if (re) m_ovr[i] = 1'b0;
        if (set_a) m_fa[i] = 1'b1; else if (clr_a) m_fa[i] = 1'b0;
        if (set_b) m_fb[i] = 1'b1; else if (clr_b) m_fb[i] = 1'b0;
        e_irq[i] = !(m_fa[i] || m_fb[i]);
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("w8.dout", d0_dout, e_dout[0]);  chk("w5.dout", d1_dout, e_dout[1]);
        chk("w8.oe",   d0_oe,   e_oe[0]);    chk("w5.oe",   d1_oe,   e_oe[1]);
        chk("w8.irq",  d0_irq,  e_irq[0]);   chk("w5.irq",  d1_irq,  e_irq[1]);
        chk("w8.stb",  d0_stb,  e_stb[0]);   chk("w5.stb",  d1_stb,  e_stb[1]);
        chk("w8.wa",   d0_wa,   e_wa[0]);    chk("w5.wa",   {3'b000, d1_wa}, e_wa[1]);
        chk("w8.wd",   d0_wd,   e_wd[0]);    chk("w5.wd",   d1_wd,   e_wd[1]);
        chk("w8.ct1",  d0_ct1,  m_regs[0][27][7]); chk("w5.ct1", d1_ct1, m_regs[1][27][7]);
        chk("w8.ct2",  d0_ct2,  m_regs[0][27][6]); chk("w5.ct2", d1_ct2, m_regs[1][27][6]);
    endtask

    // One clock: model consumes the inputs present at the edge, then compare.
    task automatic tick();
        for (int i = 0; i < 2; i++) begin
            if (ic) m_reset(i); else m_step(i);
        end
        @(posedge clk); #1;
        cyc++;
        cmp_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic idle_until(input int target);
        for (int k = 0; k < 1000 && cyc < target; k++) tick();
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        a0 = a; din = d; wr_b = 1'b0; tick();
        wr_b = 1'b1; tick();
    endtask

    task automatic rd(output logic [7:0] v8, output logic [7:0] v5);
        rd_b = 1'b0; tick();
        v8 = d0_dout; v5 = d1_dout;
        rd_b = 1'b1; tick();
    endtask

    logic [7:0] r8, r5;
    int acc_cyc, stb_cnt;
    logic [7:0] pick [8];

    initial begin
        ic = 1'b0; cs_b = 1'b1; wr_b = 1'b1; rd_b = 1'b1; a0 = 1'b0;
        din = 8'h00; tm_1 = 1'b0; tm_2 = 1'b0;
        m_reset(0); m_reset(1);
        #1 ic = 1'b1;
        #1 cmp_all();
        chk("rst.irq", d0_irq, 1'b1);
        chk("rst.dout", d0_dout, 8'h00);
        tick(); tick();
        ic = 1'b0; cs_b = 1'b0;
        idle(2);

        // Basic accepted write and busy window.
        wr(1'b0, 8'h20);
        a0 = 1'b1; din = 8'hC7; wr_b = 1'b0; tick();
        acc_cyc = cyc;
        chk("t41.stb", d0_stb, 1'b1);
        chk("t41.wa", d0_wa, 8'h20);
        chk("t41.wd", d0_wd, 8'hC7);
        chk("t41.w5stb", d1_stb, 1'b0);
        wr_b = 1'b1; tick();
        chk("t41.stb_off", d0_stb, 1'b0);
        chk("t41.wd_hold", d0_wd, 8'hC7);
        // Dropped write 10 cycles after the first, then OVR read/clear.
        idle_until(acc_cyc + 9);
        a0 = 1'b1; din = 8'h11; wr_b = 1'b0; tick();
        chk("t42.nostb", d0_stb, 1'b0);
        wr_b = 1'b1; tick();
        chk("t42.wd_same", d0_wd, 8'hC7);
        rd(r8, r5);
        chk("t42.rd1", r8, 8'hC0);
        rd(r8, r5);
        chk("t42.rd2", r8, 8'h80);
        idle_until(acc_cyc + BUSY - 1);
        rd(r8, r5);
        chk("t41.last_busy", r8, 8'h80);
        idle(4);
        // Second accepted write: busy from the first state, gone at +BUSY.
        a0 = 1'b1; din = 8'h33; wr_b = 1'b0; tick();
        acc_cyc = cyc;
        chk("t41b.stb", d0_stb, 1'b1);
        wr_b = 1'b1; rd_b = 1'b0; tick();
        chk("t41b.first_busy", d0_dout, 8'h80);
        rd_b = 1'b1;
        idle_until(acc_cyc + BUSY);
        rd(r8, r5);
        chk("t41b.not_busy", r8, 8'h00);

        // Timer flags and IRQ.
        wr(1'b0, 8'h14); wr(1'b1, 8'h0C); idle(BUSY + 2);
        tm_1 = 1'b1; tick(); tm_1 = 1'b0;
        chk("t43.irq_low", d0_irq, 1'b0);
        rd(r8, r5);
        chk("t43.status", r8, 8'h01);
        a0 = 1'b1; din = 8'h1C; wr_b = 1'b0; tick();
        chk("t43.irq_high", d0_irq, 1'b1);
        wr_b = 1'b1; tick(); idle(BUSY + 2);
        a0 = 1'b1; din = 8'h1C; wr_b = 1'b0; tm_1 = 1'b1; tick();
        tm_1 = 1'b0;
        chk("t43.set_wins", d0_irq, 1'b0);
        wr_b = 1'b1; tick(); idle(BUSY + 2);
        wr(1'b1, 8'h1C); idle(BUSY + 2);

        // ADDR_W=5 range handling and CT outputs.
        wr(1'b0, 8'h40);
        a0 = 1'b1; din = 8'h55; wr_b = 1'b0; tick();
        chk("t44.w5nostb", d1_stb, 1'b0);
        wr_b = 1'b1; tick();
        rd(r8, r5);
        chk("t44.w5nobusy", r5, 8'h00);
        idle(BUSY + 2);
        wr(1'b0, 8'h1B); wr(1'b1, 8'hC0);
        chk("t44.ct1", d1_ct1, 1'b1);
        chk("t44.ct2", d1_ct2, 1'b1);
        idle(BUSY + 2);

        // Held strobe gives one write; reset mid-busy; edge across reset.
        wr(1'b0, 8'h20);
        stb_cnt = 0;
        a0 = 1'b1; din = 8'h5A; wr_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (d0_stb) stb_cnt++;
        end
        wr_b = 1'b1;
        chk("t45.one_stb", 16'(stb_cnt), 16'd1);
        idle(3);
        din = 8'h77; wr_b = 1'b0;
        ic = 1'b1; #1;
        m_reset(0); m_reset(1);
        cmp_all();
        chk("t45.rst_wd", d0_wd, 8'h00);
        chk("t45.rst_ct1", d0_ct1, 1'b0);
        tick();
        ic = 1'b0; tick();
        chk("t45.post_stb", d0_stb, 1'b1);
        chk("t45.post_wa", d0_wa, 8'h00);
        chk("t45.post_wd", d0_wd, 8'h77);
        wr_b = 1'b1; idle(2);

        // Randomized traffic against the model.
        pick = '{8'h14, 8'h1B, 8'h20, 8'h40, 8'h0C, 8'h3C, 8'hC0, 8'h00};
        for (int n = 0; n < 3000; n++) begin
            ic   = ($urandom_range(0, 499) == 0);
            cs_b = ($urandom_range(0, 7) == 0);
            wr_b = ($urandom_range(0, 2) != 0);
            rd_b = ($urandom_range(0, 2) != 0);
            a0   = $urandom_range(0, 1) != 0;
            din  = ($urandom_range(0, 1) != 0) ? pick[$urandom_range(0, 7)] : 8'($urandom);
            tm_1 = ($urandom_range(0, 7) == 0);
            tm_2 = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
